// File: rtl/bram_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_stream_pkg
// Description : Shared widths and FSM state encoding for the BRAM stream
//               reader and its output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_stream_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with fall-through head and occupancy count.
//               Head data reads as zero while empty so the stream outputs sit
//               at a known value whenever nothing is valid.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign count     = r_wr_ptr - r_rd_ptr;
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop && !empty;
    // A push into a full FIFO is only allowed when the same cycle frees a slot
    assign w_do_push = push && (!w_full || w_do_pop);
    assign pop_data  = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // Read/write pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage array write; contents need no reset since empty masks the head
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : bram_stream_reader
// Description : Turns (address, length) read commands into a byte stream read
//               from a fixed-latency BRAM, with credit-based issue so the
//               output buffer can never overflow under backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_stream_reader
    import bram_stream_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    output logic              bram_we,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_W-1:0]       r_addr;
    logic [LEN_W-1:0]        r_remain;
    logic [READ_LATENCY-1:0] r_sr_vld;
    logic [READ_LATENCY-1:0] r_sr_last;
    logic [CNT_W-1:0]        w_fifo_count;
    logic                    w_fifo_empty;
    logic [DATA_W:0]         w_head;
    logic [7:0]              w_inflight;
    logic [15:0]             w_level;
    logic                    w_pop;
    logic                    w_issue;
    logic                    w_issue_last;
    logic                    w_accept;

    assign out_valid    = !w_fifo_empty;
    assign out_data     = w_head[DATA_W-1:0];
    assign out_last     = w_head[DATA_W];
    assign w_pop        = out_valid && out_ready;
    assign w_accept     = (r_state == IDLE) && cmd_valid;
    assign bram_addr    = r_addr;
    assign bram_we      = 1'b0;
    // Reads in flight plus buffered bytes, net of this cycle's pop, must leave
    // a free slot before another read may be issued
    assign w_level      = 16'(w_inflight) + 16'(w_fifo_count) - 16'(w_pop);
    assign w_issue      = (r_state == ISSUE) && (w_level < 16'(FIFO_DEPTH));
    assign w_issue_last = w_issue && (r_remain == LEN_W'(1));

    // Count reads currently travelling through the BRAM pipeline
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_inflight = w_inflight + 8'(r_sr_vld[i]);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next-state logic; zero-length commands are consumed without leaving IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept && (cmd_len != '0)) w_state_nxt = ISSUE;
            ISSUE:   if (w_issue_last)                w_state_nxt = DRAIN;
            DRAIN:   if (w_pop && out_last)           w_state_nxt = IDLE;
            default:                                  w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        cmd_ready = (r_state == IDLE);
        busy      = (r_state != IDLE);
        bram_en   = w_issue;
    end

    // Command address/length tracking; address wraps naturally at 1024
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_remain <= '0;
        end else if (w_accept && (cmd_len != '0)) begin
            r_addr   <= cmd_addr;
            r_remain <= cmd_len;
        end else if (w_issue) begin
            r_addr   <= r_addr + 1'b1;
            r_remain <= r_remain - 1'b1;
        end
    end

    // Shift register mirroring the BRAM latency so returning data is tagged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr_vld  <= '0;
            r_sr_last <= '0;
        end else begin
            r_sr_vld[0]  <= w_issue;
            r_sr_last[0] <= w_issue_last;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_sr_vld[i]  <= r_sr_vld[i-1];
                r_sr_last[i] <= r_sr_last[i-1];
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (r_sr_vld[READ_LATENCY-1]),
        .push_data ({r_sr_last[READ_LATENCY-1], bram_dout}),
        .pop       (w_pop),
        .pop_data  (w_head),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_bram_stream_reader
// Description : Scoreboard bench for bram_stream_reader with a 2-cycle BRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_stream_reader;

    localparam int RL = 2;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_addr = '0;
    logic [10:0] cmd_len = '0;
    logic [9:0]  bram_addr;
    logic        bram_en;
    logic        bram_we;
    logic [7:0]  bram_dout = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;

    bram_stream_reader #(.READ_LATENCY(RL), .FIFO_DEPTH(FD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .bram_addr (bram_addr),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_dout (bram_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural BRAM: two register stages from enabled address to dout
    logic [7:0] mem [1024];
    logic [7:0] bram_p1 = '0;
    initial for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'hA5;
    always @(posedge clk) begin
        if (bram_en) bram_p1 <= mem[bram_addr];
        bram_dout <= bram_p1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [8:0] exp_q[$];
    logic [9:0] iss_q[$];
    int         pops = 0;
    int         n_last = 0;
    int         first_pop_cyc = 0;
    int         last_pop_cyc = 0;
    int         last_flag_cyc = 0;
    int         outstanding = 0;
    int         max_out = 0;
    logic       held_v = 1'b0;
    logic [8:0] held = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboard compare, hold stability, outstanding tracking
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n) begin
            if (held_v && out_valid) chk("hold_stable", 32'({out_last, out_data}), 32'(held));
            held_v = out_valid && !out_ready;
            held   = {out_last, out_data};
            if (bram_en) iss_q.push_back(bram_addr);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("pop_with_empty_scoreboard", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte", 32'({out_last, out_data}), 32'(e));
                end
                pops++;
                if (pops == 1) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                if (out_last) begin
                    n_last++;
                    last_flag_cyc = cyc;
                end
            end
            outstanding = outstanding + int'(bram_en) - int'(out_valid && out_ready);
            if (outstanding > max_out) max_out = outstanding;
        end else begin
            held_v      = 1'b0;
            outstanding = 0;
        end
    end

    task automatic send(input int addr, input int len, output int ready_cyc, output int acc_cyc);
        logic [8:0] e;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_addr  = 10'(addr);
        cmd_len   = 11'(len);
        for (int i = 0; i < len; i++) begin
            e = {(i == len - 1), 8'((addr + i) % 1024) ^ 8'hA5};
            exp_q.push_back(e);
        end
        ready_cyc = -1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ready_cyc = cyc;
                break;
            end
        end
        if (ready_cyc < 0) chk("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        int k = 0;
        while ((exp_q.size() != 0 || busy) && k < budget) begin
            @(posedge clk); #1;
            if (rnd) out_ready = ($urandom_range(0, 99) >= 30);
            k++;
        end
        out_ready = 1'b1;
        chk("done_within_budget", 32'(exp_q.size() == 0 && !busy), 32'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int rc, ac, rc2, ac2, lat;
    bit saw_busy, saw_valid;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_bram_en",   32'(bram_en),   0);
        chk("rst_bram_addr", 32'(bram_addr), 0);
        chk("rst_busy",      32'(busy),      0);
        chk("rst_out_last",  32'(out_last),  0);
        chk("rst_out_data",  32'(out_data),  0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_cmd_ready", 32'(cmd_ready), 1);
        chk("bram_we_zero",       32'(bram_we),   0);

        // Basic: latency and 1 byte/cycle throughput
        pops = 0;
        send(16, 8, rc, ac);
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            if (out_valid) begin
                lat = cyc - ac;
                break;
            end
            @(posedge clk); #1;
        end
        chk("basic_first_latency", 32'(lat), 32'(RL + 1));
        wait_done(50, 0);
        chk("basic_pops", 32'(pops), 8);
        chk("basic_consecutive", 32'(last_pop_cyc - first_pop_cyc), 7);

        // Wrap around the top of the address space
        pops = 0;
        iss_q.delete();
        send(1020, 6, rc, ac);
        wait_done(50, 0);
        chk("wrap_pops", 32'(pops), 6);
        chk("wrap_issue_count", 32'(iss_q.size()), 6);
        for (int i = 0; i < 6 && i < iss_q.size(); i++)
            chk("wrap_addr", 32'(iss_q[i]), 32'((1020 + i) % 1024));

        // Random backpressure
        pops = 0;
        max_out = 0;
        send(300, 32, rc, ac);
        wait_done(500, 1);
        chk("bp_pops", 32'(pops), 32);
        chk("bp_outstanding_le_depth", 32'(max_out <= FD), 1);
        chk("bp_outstanding_nonzero", 32'(max_out > 0), 1);

        // Zero length
        pops = 0;
        saw_busy = 0;
        saw_valid = 0;
        send(5, 0, rc, ac);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy) saw_busy = 1;
            if (out_valid) saw_valid = 1;
        end
        chk("zero_busy", 32'(saw_busy), 0);
        chk("zero_no_output", 32'(saw_valid), 0);
        chk("zero_cmd_ready", 32'(cmd_ready), 1);

        // Maximum length
        pops = 0;
        n_last = 0;
        send(0, 1024, rc, ac);
        wait_done(1300, 0);
        chk("max_pops", 32'(pops), 1024);
        chk("max_one_last", 32'(n_last), 1);

        // Reset mid-stream
        pops = 0;
        send(200, 20, rc, ac);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (pops >= 5) break;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_bram_en",   32'(bram_en),   0);
        chk("midrst_bram_addr", 32'(bram_addr), 0);
        chk("midrst_busy",      32'(busy),      0);
        chk("midrst_out_data",  32'(out_data),  0);
        chk("midrst_out_last",  32'(out_last),  0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pops = 0;
        send(100, 2, rc, ac);
        wait_done(50, 0);
        repeat (5) @(posedge clk);
        chk("midrst_new_pops", 32'(pops), 2);

        // Back-to-back commands
        pops = 0;
        send(40, 4, rc, ac);
        send(60, 3, rc2, ac2);
        chk("b2b_accept_after_last", 32'(rc2), 32'(last_flag_cyc + 1));
        wait_done(60, 0);
        chk("b2b_pops", 32'(pops), 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 2, meaning cycles from an en-asserted BRAM address to valid dout (legal 1..4).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the output buffer entry count (power of two, >= READ_LATENCY+1).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1, meaning a read command is offered.
REQ-006 SHALL have port cmd_ready, output, 1, meaning a command is accepted this cycle.
REQ-007 SHALL have port cmd_addr, input, 10, the start byte address.
REQ-008 SHALL have port cmd_len, input, 11, the byte count (0..1024).
REQ-009 SHALL have port bram_addr, output, 10, the BRAM read address.
REQ-010 SHALL have port bram_en, output, 1, the BRAM port enable.
REQ-011 SHALL have port bram_we, output, 1, the BRAM write enable, constant 0.
REQ-012 SHALL have port bram_dout, input, 8, the BRAM read data.
REQ-013 SHALL have ports out_valid/out_ready, output/input, 1 each, the stream handshake.
REQ-014 SHALL have port out_data, output, 8, the stream byte.
REQ-015 SHALL have port out_last, output, 1, marking the final byte of a command.
REQ-016 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, ISSUE and DRAIN.
REQ-018 IDLE: cmd_ready=1; on cmd_valid with cmd_len>0, latch the address and length and go to ISSUE; cmd_len=0 is accepted and dropped, with no output and the state staying IDLE.
REQ-019 cmd_ready SHALL be 0 in ISSUE and DRAIN; there is no command queuing.
REQ-020 ISSUE: bram_en=1 with bram_addr=current address only when inflight+occupancy-pop < FIFO_DEPTH (pop = out_valid&out_ready this cycle); otherwise bram_en=0 and the address holds.
REQ-021 After each issued read, the address SHALL increment modulo 1024 (1023 wraps to 0) and the remaining count SHALL decrement; on the issue of the final byte, go to DRAIN.
REQ-022 A shift register of depth READ_LATENCY SHALL track issued reads and their last flag; bram_dout SHALL be written to the FIFO exactly READ_LATENCY cycles after the issue.
REQ-023 out_valid SHALL equal FIFO not-empty; out_data/out_last SHALL come from the FIFO head, and both SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 The FIFO SHALL never overflow; a same-cycle push and pop keeps occupancy unchanged.
REQ-025 DRAIN: go to IDLE in the cycle after the last-flagged byte is popped; cmd_ready SHALL rise in that IDLE cycle.
REQ-026 With out_ready held at 1, throughput SHALL be 1 byte/cycle; first-byte latency SHALL be READ_LATENCY+1 cycles from command acceptance.
REQ-027 out_last SHALL be 1 on exactly one byte per command.

Reset
REQ-028 Asserting rst_n low SHALL, asynchronously: state=IDLE, FIFO emptied, inflight cleared, bram_en=0, bram_addr=0, out_valid=0, out_last=0, out_data=0, busy=0; cmd_ready=1 after deassertion.
REQ-029 Reset mid-command SHALL abandon the command; no stale byte appears after reset release.

Structure
REQ-030 A shared package bram_stream_pkg SHALL hold: ADDR_W=10, DATA_W=8, LEN_W=11, and the state enum typedef.
REQ-031 The output buffer SHALL be one sub-module, sync_fifo (parameterized width/depth, with count output); the rest of the logic is in bram_stream_reader.

Verification
REQ-032 Bench SHALL use a behavioural 1024x8 BRAM model with READ_LATENCY=2 and mem[i]=i[7:0]^8'hA5.
REQ-033 Basic: cmd addr=16, len=8, out_ready=1 -> bytes mem[16..23] on 8 consecutive cycles, out_last on the 8th, first byte 3 cycles after acceptance.
REQ-034 Wrap: addr=1020, len=6 -> addresses 1020,1021,1022,1023,0,1 in order.
REQ-035 Backpressure: len=32 with out_ready toggling randomly (30% low) -> 32 correct bytes in order, no loss or duplication, never more than FIFO_DEPTH outstanding.
REQ-036 Zero and maximum length: len=0 -> no output, busy stays 0; len=1024 from addr=0 -> 1024 bytes, out_last only on the byte of addr 1023.
REQ-037 Reset mid-stream: assert rst_n after 5 of 20 bytes -> outputs go to reset values immediately; a new cmd addr=100, len=2 after release -> only mem[100], mem[101].
REQ-038 Back-to-back: a second command held on cmd_valid -> accepted in the cycle after the first command's out_last pop.
